// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - redirect/stall controls and PC outputs of pc_unit
// PC_RAS_EN adds the call/ret/ras_err return-address-stack signals.
interface pc_unit_if #(
   parameter int N = 32
);
   logic         stall;
   logic         trap;
   logic         jmp;
   logic [N-1:0] jmp_target;
   logic         br_taken;
   logic [N-1:0] br_target;
   logic [N-1:0] pc_out;
   logic [N-1:0] pc_plus4;
   logic         pc_valid;
   logic         misalign;
   logic [N-1:0] epc;
`ifdef PC_RAS_EN
   logic         call;
   logic         ret;
   logic         ras_err;
`endif

   modport master (
      output stall, trap, jmp, jmp_target, br_taken, br_target,
`ifdef PC_RAS_EN
      output call, ret,
      input  ras_err,
`endif
      input  pc_out, pc_plus4, pc_valid, misalign, epc
   );

   modport slave (
      input  stall, trap, jmp, jmp_target, br_taken, br_target,
`ifdef PC_RAS_EN
      input  call, ret,
      output ras_err,
`endif
      output pc_out, pc_plus4, pc_valid, misalign, epc
   );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with prioritised redirects, fetch bubble and EPC capture
// Optional return-address stack enabled by PC_RAS_EN.
module pc_unit #(
   parameter int           N            = 32,
   parameter logic [N-1:0] RESET_VECTOR = N'(32'h0040_0000),
   parameter logic [N-1:0] TRAP_VECTOR  = N'(32'h0040_0100),
   parameter int           RAS_DEPTH    = 4
) (
   input  logic     clk,
   input  logic     reset,
   pc_unit_if.slave bus
);

   generate
      if (N < 8 || RAS_DEPTH < 2) begin : g_bad_param
         $error("pc_unit: N must be >= 8 and RAS_DEPTH >= 2");
      end
   endgenerate

   typedef enum logic {HOLD, RUN} state_t;

   state_t       state_q, state_d;
   logic [N-1:0] pc_q, pc_d;
   logic         valid_q, valid_d;
   logic         misalign_q, misalign_d;
   logic [N-1:0] epc_q, epc_d;
   logic [N-1:0] pc_plus4;
   logic [N-1:0] target;

   assign pc_plus4 = pc_q + N'(4);
   assign target   = bus.jmp ? bus.jmp_target : bus.br_target;

`ifdef PC_RAS_EN
   localparam int AW = $clog2(RAS_DEPTH);

   logic [N-1:0]  ras_mem [RAS_DEPTH];
   logic [AW-1:0] ras_ptr_q, ras_ptr_d;
   logic [AW:0]   ras_cnt_q, ras_cnt_d;
   logic          ras_err_q, ras_err_d;
   logic          ras_push;
   logic [N-1:0]  ras_top;

   // ras_ptr_q is the next write slot; the top of stack sits just below it
   assign ras_top = ras_mem[ras_ptr_q - AW'(1)];
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      valid_d    = valid_q;
      misalign_d = 1'b0;
      epc_d      = epc_q;
`ifdef PC_RAS_EN
      ras_ptr_d  = ras_ptr_q;
      ras_cnt_d  = ras_cnt_q;
      ras_err_d  = 1'b0;
      ras_push   = 1'b0;
`endif
      case (state_q)
         HOLD: begin
            state_d = RUN;
            valid_d = 1'b1;
         end
         RUN: begin
            valid_d = 1'b1;
            if (bus.trap) begin
               pc_d    = TRAP_VECTOR;
               epc_d   = pc_q;
               valid_d = 1'b0;
            end
`ifdef PC_RAS_EN
            else if (bus.ret) begin
               valid_d = 1'b0;
               if (ras_cnt_q == '0) begin
                  pc_d      = TRAP_VECTOR;
                  epc_d     = pc_q;
                  ras_err_d = 1'b1;
               end else begin
                  pc_d      = ras_top;
                  ras_ptr_d = ras_ptr_q - AW'(1);
                  ras_cnt_d = ras_cnt_q - (AW+1)'(1);
               end
            end
`endif
            else if (bus.jmp || bus.br_taken) begin
               valid_d = 1'b0;
               if (target[1:0] != 2'b00) begin
                  pc_d       = TRAP_VECTOR;
                  epc_d      = target;
                  misalign_d = 1'b1;
               end else begin
                  pc_d = target;
               end
`ifdef PC_RAS_EN
               // a full stack keeps wrapping, silently dropping the oldest return
               if (bus.jmp && bus.call) begin
                  ras_push  = 1'b1;
                  ras_ptr_d = ras_ptr_q + AW'(1);
                  if (ras_cnt_q != (AW+1)'(RAS_DEPTH)) begin
                     ras_cnt_d = ras_cnt_q + (AW+1)'(1);
                  end
               end
`endif
            end else if (!bus.stall) begin
               pc_d = pc_plus4;
            end
         end
         default: state_d = HOLD;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= HOLD;
         pc_q       <= RESET_VECTOR;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
         epc_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         valid_q    <= valid_d;
         misalign_q <= misalign_d;
         epc_q      <= epc_d;
      end
   end

`ifdef PC_RAS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ras_ptr_q <= '0;
         ras_cnt_q <= '0;
         ras_err_q <= 1'b0;
      end else begin
         ras_ptr_q <= ras_ptr_d;
         ras_cnt_q <= ras_cnt_d;
         ras_err_q <= ras_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ras_push) begin
         ras_mem[ras_ptr_q] <= pc_plus4;
      end
   end

   assign bus.ras_err = ras_err_q;
`endif

   assign bus.pc_out   = pc_q;
   assign bus.pc_plus4 = pc_plus4;
   assign bus.pc_valid = valid_q;
   assign bus.misalign = misalign_q;
   assign bus.epc      = epc_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard bench for pc_unit with directed vectors
// Expected state after each edge is queued by the driver and checked by a negedge monitor.
module tb_pc_unit;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   pc_unit_if #(.N(32)) bus ();

   pc_unit u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int          id;
      logic [31:0] pc;
      logic        valid;
      logic        mis;
      logic [31:0] epc;
      logic        ras;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   vec_id   = 0;

   task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s vec %0d: got 0x%08h want 0x%08h", name, id, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("pc_out",   e.id, bus.pc_out,          e.pc);
         chk("pc_plus4", e.id, bus.pc_plus4,        e.pc + 32'd4);
         chk("pc_valid", e.id, {31'd0, bus.pc_valid}, {31'd0, e.valid});
         chk("misalign", e.id, {31'd0, bus.misalign}, {31'd0, e.mis});
         chk("epc",      e.id, bus.epc,             e.epc);
`ifdef PC_RAS_EN
         chk("ras_err",  e.id, {31'd0, bus.ras_err}, {31'd0, e.ras});
`endif
      end
   end

   task automatic push_exp(input logic [31:0] pc, input logic v, input logic m,
                           input logic [31:0] epc, input logic ras);
      exp_t e;
      e.id = vec_id; e.pc = pc; e.valid = v; e.mis = m; e.epc = epc; e.ras = ras;
      exp_q.push_back(e);
      vec_id++;
   endtask

   task automatic set_in(input logic st, input logic tr, input logic j, input logic [31:0] jt,
                         input logic b, input logic [31:0] bt, input logic c, input logic r);
      bus.stall = st; bus.trap = tr; bus.jmp = j; bus.jmp_target = jt;
      bus.br_taken = b; bus.br_target = bt;
`ifdef PC_RAS_EN
      bus.call = c; bus.ret = r;
`else
      if (c || r) $display("note: call/ret ignored without return-address stack");
`endif
   endtask

   // called at a negedge: drive inputs, let one rising edge pass, queue expected result
   task automatic step(input logic st, input logic tr, input logic j, input logic [31:0] jt,
                       input logic b, input logic [31:0] bt, input logic c, input logic r,
                       input logic [31:0] e_pc, input logic e_v, input logic e_m,
                       input logic [31:0] e_epc, input logic e_ras);
      set_in(st, tr, j, jt, b, bt, c, r);
      @(posedge clk);
      #1;
      push_exp(e_pc, e_v, e_m, e_epc, e_ras);
      @(negedge clk);
   endtask

   task automatic idle(input logic [31:0] e_pc, input logic e_v, input logic [31:0] e_epc);
      step(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, e_pc, e_v, 1'b0, e_epc, 1'b0);
   endtask

   task automatic jump(input logic [31:0] jt, input logic c, input logic [31:0] e_pc,
                       input logic e_m, input logic [31:0] e_epc);
      step(0, 0, 1, jt, 0, 32'h0, c, 0, e_pc, 1'b0, e_m, e_epc, 1'b0);
   endtask

   initial begin
      reset = 1'b0;
      set_in(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
      push_exp(32'h0040_0000, 0, 0, 32'h0, 0);
      @(negedge clk);
      reset = 1'b1;

      idle(32'h0040_0000, 1, 32'h0);
      idle(32'h0040_0004, 1, 32'h0);
      idle(32'h0040_0008, 1, 32'h0);
      for (int i = 0; i < 3; i++)
         step(1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0040_0008, 1, 0, 32'h0, 0);
      idle(32'h0040_000C, 1, 32'h0);
      step(1, 0, 0, 32'h0, 1, 32'h0040_0200, 0, 0, 32'h0040_0200, 0, 0, 32'h0, 0);
      step(0, 0, 1, 32'h0040_0300, 1, 32'h0040_0400, 0, 0, 32'h0040_0300, 0, 0, 32'h0, 0);
      idle(32'h0040_0304, 1, 32'h0);
      jump(32'h0040_0302, 0, 32'h0040_0100, 1, 32'h0040_0302);
      idle(32'h0040_0104, 1, 32'h0040_0302);
      jump(32'h0040_0010, 0, 32'h0040_0010, 0, 32'h0040_0302);
      step(0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0040_0100, 0, 0, 32'h0040_0010, 0);
      step(0, 1, 1, 32'h0040_0002, 0, 32'h0, 0, 0, 32'h0040_0100, 0, 0, 32'h0040_0100, 0);
      jump(32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 32'h0040_0100);
      idle(32'h0000_0000, 1, 32'h0040_0100);
      step(0, 0, 0, 32'h0, 1, 32'h0000_0201, 0, 0, 32'h0040_0100, 0, 1, 32'h0000_0201, 0);
      step(1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0040_0100, 1, 0, 32'h0000_0201, 0);

      // asynchronous reset between edges
      set_in(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
      @(posedge clk);
      #2 reset = 1'b0;
      #1 push_exp(32'h0040_0000, 0, 0, 32'h0, 0);
      @(negedge clk);
      reset = 1'b1;
      idle(32'h0040_0000, 1, 32'h0);
      idle(32'h0040_0004, 1, 32'h0);

`ifdef PC_RAS_EN
      jump(32'h0040_0010, 0, 32'h0040_0010, 0, 32'h0);
      jump(32'h0040_0800, 1, 32'h0040_0800, 0, 32'h0);
      step(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0040_0014, 0, 0, 32'h0, 0);
      jump(32'h0040_0800, 1, 32'h0040_0800, 0, 32'h0);
      jump(32'h0040_0900, 1, 32'h0040_0900, 0, 32'h0);
      jump(32'h0040_0A00, 1, 32'h0040_0A00, 0, 32'h0);
      jump(32'h0040_0B00, 1, 32'h0040_0B00, 0, 32'h0);
      jump(32'h0040_0C00, 1, 32'h0040_0C00, 0, 32'h0);
      step(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0040_0B04, 0, 0, 32'h0, 0);
      step(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0040_0A04, 0, 0, 32'h0, 0);
      step(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0040_0904, 0, 0, 32'h0, 0);
      step(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0040_0804, 0, 0, 32'h0, 0);
      step(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0040_0100, 0, 0, 32'h0040_0804, 1);
      idle(32'h0040_0104, 1, 32'h0040_0804);
`endif

      #1;
      chk("queue_drained", vec_id, exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the single-cycle/pipelined RISC-V core.
- Generalises the plain PC register: N-bit PC, programmable reset/trap vectors, stall hold, prioritised redirects (trap, jump, branch), fetch-valid bubble after reset, misaligned-target trap with captured EPC.
- Sits between the branch/jump resolution logic and instruction memory; pc_out drives the IMEM address.

Parameters:
- N, 32, PC width in bits (>=8).
- RESET_VECTOR, 32'h0040_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0040_0100, PC loaded on trap or misaligned redirect.
- RAS_DEPTH, 4, return-address-stack entries (power of 2, >=2); used only with PC_RAS_EN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hold PC (pipeline stall).
- trap  input  1  synchronous exception request.
- jmp  input  1  unconditional jump request.
- jmp_target  input  N  jump destination.
- br_taken  input  1  resolved taken branch.
- br_target  input  N  branch destination.
- pc_out  output  N  current PC (IMEM address).
- pc_plus4  output  N  pc_out + 4, combinational, mod 2^N.
- pc_valid  output  1  pc_out holds a fetchable address.
- misalign  output  1  one-cycle pulse: redirect target had bits[1:0] != 0.
- epc  output  N  PC of faulting event (trap or misaligned target).

Behaviour:
- Reset asserted (reset=0, async): pc_out=RESET_VECTOR, pc_valid=0, misalign=0, epc=0, FSM=HOLD. Takes effect mid-operation without waiting for a clock edge.
- FSM states: HOLD, RUN.
  - HOLD: the first rising edge after reset release moves to RUN with pc_valid=1 and pc_out unchanged (RESET_VECTOR); all inputs ignored in HOLD.
  - RUN persists until reset.
- Next-PC priority in RUN, evaluated each rising edge, one-cycle latency:
  1. trap: pc<=TRAP_VECTOR, epc<=pc_out.
  2. jmp: pc<=jmp_target.
  3. br_taken: pc<=br_target.
  4. stall: pc holds.
  5. otherwise: pc<=pc_plus4.
- Redirects (1-3) override stall.
- Simultaneous jmp and br_taken: jmp wins; branch is dropped.
- Misaligned redirect (selected jmp/br target with bits[1:0] != 0):
  - pc<=TRAP_VECTOR, epc<=offending target, misalign=1 for exactly the next cycle.
  - A trap in the same cycle takes precedence: epc<=pc_out, no misalign pulse.
- pc_valid drops to 0 for exactly one cycle after any redirect (bubble for the fetch flush). It stays 1 during stall.
- Wrap-around: pc_out=32'hFFFF_FFFC increments to 0. No flag. pc_plus4 wraps identically.
- epc changes only on trap or misalign events.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined:
  - Adds ports call (in, 1) and ret (in, 1), plus ras_err (out, 1 pulse).
  - jmp with call=1 pushes pc_plus4 onto a RAS_DEPTH circular stack; when full, the oldest entry is overwritten.
  - ret=1 (priority between trap and jmp): pc<=top of stack, then pop.
  - ret on empty stack: pc<=TRAP_VECTOR, epc<=pc_out, ras_err pulses 1 cycle.
  - Reset empties the stack.
- Undefined: ports call/ret/ras_err absent, no stack storage, behaviour exactly as above.

Test Plan:
- Reset release -> pc_out=0x0040_0000, pc_valid=0 for 1 cycle, then 0x0040_0000 valid, 0x0040_0004, 0x0040_0008 on successive edges.
- stall=1 for 3 cycles at 0x0040_0008 -> pc holds 0x0040_0008, pc_valid=1; release -> 0x0040_000C.
- br_taken=1, br_target=0x0040_0200 with stall=1 -> pc=0x0040_0200, pc_valid=0 for one cycle; jmp+br together (0x0040_0300 / 0x0040_0400) -> pc=0x0040_0300.
- jmp_target=0x0040_0302 -> pc=0x0040_0100, misalign pulse 1 cycle, epc=0x0040_0302; trap at pc=0x0040_0010 -> pc=0x0040_0100, epc=0x0040_0010.
- Force pc=0xFFFF_FFFC via jmp -> next pc=0x0000_0000; assert reset mid-cycle -> pc_out=0x0040_0000 immediately, pc_valid=0.
- PC_RAS_EN: call at 0x0040_0010 to 0x0040_0800, then ret -> pc=0x0040_0014. 5 calls with RAS_DEPTH=4 then 5 rets -> 4 correct returns, 5th gives ras_err and pc=0x0040_0100.
